// File: rtl/get_sign_parse.sv
// Receive-side signature deserializer: shifts a MSB-first word stream into a
// sigma buffer and exposes its fields. Optional idle timeout: PARSE_TIMEOUT_EN.
module get_sign_parse #(
  parameter int WORD_W  = 32,
  parameter int SIG_W   = 37760,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              parse_start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [255:0]      h_t_o,
  output logic [255:0]      salt_o,
  output logic [255:0]      C_star_o,
  output logic [127:0]      seed_triangle_o,
  output logic [2047:0]     msgs_o,
  output logic [30719:0]    seed_lambda_o,
  output logic [4095:0]     aux_triangle_o,
`ifdef PARSE_TIMEOUT_EN
  output logic              parse_err,
`endif
  output logic              parse_end
);

  localparam int NUM_WORDS = SIG_W / WORD_W;
  localparam int Z_W       = 9216;

  typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} state_t;

  state_t            state_reg;
  logic [12:0]       cnt_reg;
  logic [SIG_W-1:0]  sig_reg;
  logic              parse_end_reg;
  logic              accept;

`ifdef PARSE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_reg;
  logic              parse_err_reg;
  assign parse_err = parse_err_reg;
`endif

  assign in_ready  = (state_reg == RECV);
  assign accept    = in_valid && in_ready;
  assign parse_end = parse_end_reg;

  assign h_t_o           = sig_reg[37759:37504];
  assign salt_o          = sig_reg[37503:37248];
  assign C_star_o        = sig_reg[37247:36992];
  assign seed_triangle_o = sig_reg[36991:36864];

  // Z[0] sits highest in sigma; each Z[i] splits msgs | seed_lambda | aux_triangle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_z
    assign msgs_o[2047-gi*512 -: 512]          = sig_reg[Z_W*(4-gi)-1 -: 512];
    assign seed_lambda_o[30719-gi*7680 -: 7680] = sig_reg[Z_W*(4-gi)-1-512 -: 7680];
    assign aux_triangle_o[4095-gi*1024 -: 1024] = sig_reg[Z_W*(4-gi)-1-8192 -: 1024];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sig_reg       <= '0;
      parse_end_reg <= 1'b0;
`ifdef PARSE_TIMEOUT_EN
      idle_reg      <= '0;
      parse_err_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (parse_start && !parse_end_reg) begin
            state_reg <= RECV;
            cnt_reg   <= '0;
`ifdef PARSE_TIMEOUT_EN
            idle_reg  <= '0;
`endif
          end
        end
        RECV: begin
          if (!parse_start) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (accept) begin
            sig_reg <= {sig_reg[SIG_W-WORD_W-1:0], in_data};
`ifdef PARSE_TIMEOUT_EN
            idle_reg <= '0;
`endif
            if (cnt_reg == 13'(NUM_WORDS - 1)) begin
              state_reg     <= DONE;
              parse_end_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 13'd1;
            end
          end
`ifdef PARSE_TIMEOUT_EN
          // Trip on the TIMEOUT-th idle edge so parse_err appears TIMEOUT cycles after the last accept.
          else if (idle_reg == IDLE_W'(TIMEOUT - 1)) begin
            state_reg     <= ERR;
            parse_err_reg <= 1'b1;
          end else begin
            idle_reg <= idle_reg + 1'b1;
          end
`endif
        end
        DONE: begin
          if (!parse_start) begin
            state_reg     <= IDLE;
            parse_end_reg <= 1'b0;
          end
        end
        ERR: begin
          if (!parse_start) begin
            state_reg <= IDLE;
`ifdef PARSE_TIMEOUT_EN
            parse_err_reg <= 1'b0;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_get_sign_parse.sv
// Directed bench for get_sign_parse: gapless, round-trip, backpressure, abort,
// mid-stream reset and (with PARSE_TIMEOUT_EN) the idle timeout.
module tb_get_sign_parse;
    localparam int W  = 32;
    localparam int SW = 37760;
    localparam int NW = SW / W;

    logic           clk = 1'b0;
    logic           reset, parse_start, in_valid, in_ready, parse_end;
    logic [W-1:0]   in_data;
    logic [255:0]   h_t_o, salt_o, C_star_o;
    logic [127:0]   seed_triangle_o;
    logic [2047:0]  msgs_o;
    logic [30719:0] seed_lambda_o;
    logic [4095:0]  aux_triangle_o;
`ifdef PARSE_TIMEOUT_EN
    logic           parse_err;
`endif

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int acc0;

    logic [SW-1:0]  sig;
    logic [255:0]   h, sa, cs, h_save;
    logic [127:0]   st;
    logic [2047:0]  m;
    logic [30719:0] sl;
    logic [4095:0]  ax;

    get_sign_parse #(.WORD_W(W), .SIG_W(SW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .parse_start(parse_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .h_t_o(h_t_o), .salt_o(salt_o),
        .C_star_o(C_star_o), .seed_triangle_o(seed_triangle_o), .msgs_o(msgs_o),
        .seed_lambda_o(seed_lambda_o), .aux_triangle_o(aux_triangle_o),
`ifdef PARSE_TIMEOUT_EN
        .parse_err(parse_err),
`endif
        .parse_end(parse_end)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (in_valid && in_ready) accepts++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("PASS %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [SW-1:0] seq_sig(input logic [W-1:0] base);
        logic [SW-1:0] s;
        for (int k = 0; k < NW; k++) s[SW-1-k*W -: W] = base + W'(k);
        return s;
    endfunction

    task automatic send(input logic [SW-1:0] s, input int first, input int last, input bit gaps);
        for (int k = first; k <= last; k++) begin
            in_data = s[SW-1-k*W -: W];
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (gaps && k < NW - 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic start_parse();
        parse_start = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic stop_parse();
        parse_start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; parse_start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", in_ready, 1'b0);
        chk("reset_end", parse_end, 1'b0);
        chk("reset_h_t", h_t_o, 256'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        sig = seq_sig(32'd0);
        start_parse();
        chk("recv_ready", in_ready, 1'b1);
        send(sig, 0, NW - 2, 1'b0);
        chk("seq_end_early", parse_end, 1'b0);
        send(sig, NW - 1, NW - 1, 1'b0);
        chk("seq_end", parse_end, 1'b1);
        chk("seq_h_t", h_t_o, {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
        chk("seq_salt", salt_o[255:224], 32'd8);
        chk("seq_cstar", C_star_o[255:224], 32'd16);
        chk("seq_seed_tri", seed_triangle_o, {32'd24, 32'd25, 32'd26, 32'd27});
        chk("seq_msgs0", msgs_o[2047 -: 32], 32'd28);
        chk("seq_lambda0", seed_lambda_o[30719 -: 32], 32'd44);
        chk("seq_aux0", aux_triangle_o[4095 -: 32], 32'd284);
        chk("seq_msgs3", msgs_o[511 -: 32], 32'd892);
        chk("seq_aux_last", aux_triangle_o[31:0], 32'd1179);
        chk("done_ready", in_ready, 1'b0);
        stop_parse();
        chk("end_drop", parse_end, 1'b0);
        chk("buf_retained", aux_triangle_o[31:0], 32'd1179);

        h  = {32{8'hA5}};
        sa = {32{8'h3C}};
        for (int i = 0; i < 8; i++) cs[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) st[i*32 +: 32] = $urandom;
        for (int i = 0; i < 64; i++) m[i*32 +: 32] = $urandom;
        for (int i = 0; i < 960; i++) sl[i*32 +: 32] = $urandom;
        for (int i = 0; i < 128; i++) ax[i*32 +: 32] = $urandom;
        sig = {h, sa, cs, st,
               m[2047 -: 512], sl[30719 -: 7680], ax[4095 -: 1024],
               m[1535 -: 512], sl[23039 -: 7680], ax[3071 -: 1024],
               m[1023 -: 512], sl[15359 -: 7680], ax[2047 -: 1024],
               m[511 -: 512],  sl[7679 -: 7680],  ax[1023 -: 1024]};
        start_parse();
        send(sig, 0, NW - 1, 1'b0);
        chk("rt_end", parse_end, 1'b1);
        chk("rt_h_t", h_t_o, h);
        chk("rt_salt", salt_o, sa);
        chk("rt_cstar", C_star_o, cs);
        chk("rt_seed_tri", seed_triangle_o, st);
        chk("rt_msgs_eq", msgs_o === m, 1'b1);
        chk("rt_lambda_eq", seed_lambda_o === sl, 1'b1);
        chk("rt_aux_eq", aux_triangle_o === ax, 1'b1);
        stop_parse();

        sig = seq_sig(32'd0);
        acc0 = accepts;
        start_parse();
        send(sig, 0, NW - 2, 1'b1);
        chk("bp_end_early", parse_end, 1'b0);
        send(sig, NW - 1, NW - 1, 1'b1);
        chk("bp_end", parse_end, 1'b1);
        chk("bp_h_t", h_t_o, {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
        chk("bp_aux_last", aux_triangle_o[31:0], 32'd1179);
        h_save = h_t_o;
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        chk("bp_done_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_count", accepts - acc0, NW);
        chk("bp_stable", h_t_o, h_save);
        stop_parse();

        start_parse();
        send(seq_sig(32'd0), 0, 499, 1'b0);
        stop_parse();
        chk("abort_ready", in_ready, 1'b0);
        chk("abort_end", parse_end, 1'b0);
        sig = seq_sig(32'hFFFF0000);
        start_parse();
        send(sig, 0, NW - 2, 1'b0);
        chk("abort_end_early", parse_end, 1'b0);
        send(sig, NW - 1, NW - 1, 1'b0);
        chk("abort_end_full", parse_end, 1'b1);
        chk("abort_h_t_top", h_t_o[255:224], 32'hFFFF0000);
        chk("abort_aux_last", aux_triangle_o[31:0], 32'hFFFF049B);
        stop_parse();

        start_parse();
        send(seq_sig(32'd0), 0, 699, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_end", parse_end, 1'b0);
        chk("rst_h_t", h_t_o, 256'd0);
        chk("rst_aux_zero", aux_triangle_o === 4096'd0, 1'b1);
        parse_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        sig = seq_sig(32'd0);
        start_parse();
        send(sig, 0, NW - 1, 1'b0);
        chk("rst_fresh_end", parse_end, 1'b1);
        chk("rst_fresh_seed_tri", seed_triangle_o, {32'd24, 32'd25, 32'd26, 32'd27});
        chk("rst_fresh_aux_last", aux_triangle_o[31:0], 32'd1179);
        stop_parse();

`ifdef PARSE_TIMEOUT_EN
        start_parse();
        send(seq_sig(32'd0), 0, 9, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        chk("to_err_early", parse_err, 1'b0);
        @(posedge clk); #1;
        chk("to_err", parse_err, 1'b1);
        chk("to_end", parse_end, 1'b0);
        chk("to_ready", in_ready, 1'b0);
        stop_parse();
        chk("to_err_clear", parse_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/get_sign_parse.md
Name: get_sign_parse

Overview:
- Receive side of signature transport: deserializes a word stream carrying a 37760-bit Picnic-on-SM4 signature sigma and splits it back into its fields.
- Field layout is the exact inverse of the signature packer: sigma = {h_t, salt, C_star, seed_triangle, Z[0], Z[1], Z[2], Z[3]}, with Z[i] = {msgs[i](512), seed_lambda[i](7680), aux_triangle[i](1024)}.
- Sits between the verifier's input channel and the verification datapath.
- Uses the same start/end level handshake as the rest of the sign/verify pipeline.

Parameters:
- WORD_W, 32: stream word width; legal values 8, 16, 32, 64, 128.
- SIG_W, 37760: sigma width; fixed, not to be overridden.
- TIMEOUT, 1024: maximum idle cycles between accepted words while receiving. Used only with PARSE_TIMEOUT_EN.
- Derived localparam NUM_WORDS = SIG_W/WORD_W (1180 at default).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- parse_start  in  1  level request to receive one signature.
- in_data  in  WORD_W  stream word; the first word is sigma[SIG_W-1 -: WORD_W] (MSB first).
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a word this cycle.
- h_t_o  out  256  parsed h_t.
- salt_o  out  256  parsed salt.
- C_star_o  out  256  parsed C_star.
- seed_triangle_o  out  128  parsed seed_triangle.
- msgs_o  out  2048  {msgs[0],msgs[1],msgs[2],msgs[3]}.
- seed_lambda_o  out  30720  {seed_lambda[0..3]}, 7680 bits each, index 0 most significant.
- aux_triangle_o  out  4096  {aux_triangle[0..3]}, index 0 most significant.
- parse_end  out  1  outputs valid; held high until parse_start falls.
- parse_err  out  1  timeout abort; only present with PARSE_TIMEOUT_EN.

Behaviour:
- Reset (async, high):
  - state=IDLE; word counter=0.
  - SIG_W-bit buffer=0, so all field outputs are 0.
  - in_ready=0, parse_end=0, parse_err=0.
- Buffer and fields:
  - Each accepted word shifts in from the LSB end: buf <= {buf[SIG_W-WORD_W-1:0], in_data}.
  - Fields are fixed slices of buf. h_t_o=buf[37759:37504], salt_o=buf[37503:37248], C_star_o=buf[37247:36992], seed_triangle_o=buf[36991:36864].
  - Z[0]=buf[36863:27648] and so on down to Z[3]=buf[9215:0]. Each Z[i] is split msgs|seed_lambda|aux_triangle, MSB first.
- States:
  - IDLE:
    - in_ready=0.
    - If parse_start=1 and parse_end=0: go to RECV, counter<=0.
  - RECV:
    - in_ready=1 combinationally.
    - A word is accepted when in_valid&&in_ready; on accept, shift buf and counter++.
    - On accept with counter==NUM_WORDS-1: go to DONE and set parse_end<=1. parse_end is visible the cycle after the last word is accepted.
    - in_valid low inserts wait cycles; there is no limit unless PARSE_TIMEOUT_EN.
  - DONE:
    - in_ready=0; further words are not consumed; fields are stable.
    - When parse_start=0: parse_end<=0 and go to IDLE. Buffer is retained.
- parse_start falls while in RECV: abort to IDLE next cycle. Counter clears, parse_end stays 0, buffer contents are don't-care.
- parse_start held high after DONE→IDLE: no restart until parse_end has dropped. Since that happens in the same edge, a restart requires parse_start to be low for at least one cycle.
- Reset asserted mid-RECV: immediate return to reset values. The partial word count is discarded.
- The counter is wide enough for NUM_WORDS at WORD_W=8 (13 bits) and never wraps.

Optional Feature:
- Macro PARSE_TIMEOUT_EN.
- Defined:
  - An idle counter runs in RECV. It clears on every accepted word and increments on cycles with no accept.
  - When it reaches TIMEOUT: go to ERR, set parse_err=1, in_ready=0, parse_end=0.
  - ERR exits to IDLE when parse_start=0, clearing parse_err.
  - parse_err resets to 0.
- Undefined: no parse_err port and no idle counter; RECV waits indefinitely.

Test Plan:
- Sequential words, no gaps. Assert parse_start, drive word k = k for k=0..1179 with in_valid=1 → parse_end rises 1 cycle after word 1179 is accepted. h_t_o = {32'd0,32'd1,…,32'd7}; seed_triangle_o = {32'd24,…,32'd27}; aux_triangle_o[31:0] = 32'd1179.
- Round trip with the signature packer. Pack h_t=256'hA5…, salt=256'h3C…, random msgs/seed_lambda/aux, stream the sigma MSB-first → every parsed field equals the packer input bit-exact.
- Backpressure. Toggle in_valid 1/0 every cycle (2359 cycles) → same fields as the gapless run. Word count = 1180; in_ready=0 in DONE even with in_valid=1.
- Abort. Drop parse_start after 500 words, then restart and send 1180 words 0xFFFF0000+k → parse_end only after the second full stream, with h_t_o[255:224]=32'hFFFF0000.
- Reset mid-stream. Assert reset after 700 words → next cycle all outputs are 0 and in_ready=0. A fresh full stream parses correctly.
- PARSE_TIMEOUT_EN, TIMEOUT=16. Stop in_valid after 10 words → parse_err=1 exactly 16 cycles after the last accept, parse_end=0. Dropping parse_start clears parse_err.
